// File: rtl/leading_one_pkg.sv
// Shared types and constants for the leading-one encoder family and its
// inverse (index_accumulator).
package leading_one_pkg;

    localparam int WIDTH = 9;
    localparam int IDX_W = 4;

    // All-ones index means "no bit set".
    localparam logic [IDX_W-1:0] IDX_NONE  = 4'hF;
    localparam logic [IDX_W-1:0] COUNT_MAX = 4'hF;

    // Bit positions within err_o.
    localparam int ERR_INVALID = 0;
    localparam int ERR_DUP     = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } acc_state_t;

    // Beat counter increment that sticks at COUNT_MAX.
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] c);
        return (c == COUNT_MAX) ? c : c + IDX_W'(1);
    endfunction

endpackage

// File: rtl/index_to_onehot.sv
// Expands a bit index into a WIDTH-bit one-hot. The null code yields zero
// silently; indices past the word width yield zero and raise invalid.
module index_to_onehot
    import leading_one_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot,
    output logic             invalid
);

    // Combinational decode with explicit defaults so no latch is inferred.
    always_comb begin
        onehot  = '0;
        invalid = 1'b0;
        if (index != IDX_NONE) begin
            if (int'(index) < WIDTH) begin
                onehot = WIDTH'(1) << index;
            end else begin
                invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/index_accumulator.sv
// Rebuilds a bit vector from a stream of bit indices. Beats are OR-ed into an
// accumulator; the last beat of a word loads the result, beat count and
// error flags into a single output register with valid/ready handshake.
module index_accumulator
    import leading_one_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IDX_W-1:0] index_i,
    input  logic             last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] number_o,
    output logic [IDX_W-1:0] count_o,
    output logic [1:0]       err_o
);

    acc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] cnt;
    logic [1:0]       perr;

    logic [WIDTH-1:0] onehot;
    logic             invalid;
    logic [WIDTH-1:0] acc_view;
    logic [WIDTH-1:0] word_next;
    logic [IDX_W-1:0] cnt_next;
    logic [1:0]       beat_err;
    logic [1:0]       err_next;
    logic             accept;

    index_to_onehot u_decode (
        .index   (index_i),
        .onehot  (onehot),
        .invalid (invalid)
    );

    // Input may advance whenever the output slot is free or being drained.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // In IDLE the accumulator is known-empty, so never let stale bits leak.
    assign acc_view  = (state == COLLECT) ? acc : '0;
    assign word_next = acc_view | onehot;
    assign cnt_next  = sat_inc(cnt);
    assign err_next  = perr | beat_err;

    // Per-beat error flags: out-of-range index and re-set of an existing bit.
    always_comb begin
        beat_err              = '0;
        beat_err[ERR_INVALID] = invalid;
        beat_err[ERR_DUP]     = |(acc_view & onehot);
    end

    // Accumulator FSM and output register; a last beat loads the output and
    // clears the accumulator on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            perr        <= '0;
            out_valid_o <= 1'b0;
            number_o    <= '0;
            count_o     <= '0;
            err_o       <= '0;
        end else begin
            if (accept) begin
                if (last_i) begin
                    number_o <= word_next;
                    count_o  <= cnt_next;
                    err_o    <= err_next;
                    acc      <= '0;
                    cnt      <= '0;
                    perr     <= '0;
                    state    <= IDLE;
                end else begin
                    acc      <= word_next;
                    cnt      <= cnt_next;
                    perr     <= err_next;
                    state    <= COLLECT;
                end
            end
            if (accept && last_i) begin
                out_valid_o <= 1'b1;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_index_accumulator.sv
// Scoreboard bench for index_accumulator: the driver pushes the expected word
// for every accepted last beat, a negedge monitor compares and pops on each
// output handshake.
module tb_index_accumulator;
    import leading_one_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] index_i = 4'd0;
    logic       last_i = 1'b0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [8:0] number_o;
    logic [3:0] count_o;
    logic [1:0] err_o;

    typedef struct packed {
        logic [8:0] w;
        logic [3:0] c;
        logic [1:0] e;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    int   cur[$];
    exp_t sb[$];

    index_accumulator dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .index_i     (index_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .number_o    (number_o),
        .count_o     (count_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word is the set of in-range indices seen; a duplicate is
    // any in-range index occurring more than once; count saturates at 15.
    task automatic close_word();
        int   hits[16];
        exp_t x;
        x = '0;
        foreach (hits[k]) hits[k] = 0;
        foreach (cur[i]) hits[cur[i]]++;
        for (int k = 0; k < 9; k++) begin
            if (hits[k] > 0) x.w[k] = 1'b1;
            if (hits[k] > 1) x.e[1] = 1'b1;
        end
        for (int k = 9; k < 15; k++) if (hits[k] > 0) x.e[0] = 1'b1;
        x.c = (cur.size() > 15) ? 4'd15 : 4'(cur.size());
        sb.push_back(x);
        cur.delete();
    endtask

    // Monitor: compare the presented word every cycle; pop on handshake.
    always @(negedge clk) begin
        if (rst_ni && out_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected no word", number_o);
            end else begin
                check("sb_number", 32'(number_o), 32'(sb[0].w));
                check("sb_count", 32'(count_o), 32'(sb[0].c));
                check("sb_err", 32'(err_o), 32'(sb[0].e));
                if (out_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [3:0] idx, input logic lst);
        bit ok;
        ok = 1'b0;
        in_valid_i = 1'b1;
        index_i    = idx;
        last_i     = lst;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready_o;
            tick();
        end
        in_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else begin
            cur.push_back(int'(idx));
            if (lst) close_word();
        end
    endtask

    task automatic expect_out(input logic [8:0] w, input logic [3:0] c, input logic [1:0] e);
        check("out_valid", 32'(out_valid_o), 32'd1);
        check("out_number", 32'(number_o), 32'(w));
        check("out_count", 32'(count_o), 32'(c));
        check("out_err", 32'(err_o), 32'(e));
    endtask

    task automatic drain();
        rand_ready  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending words expected 0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] idx;
        int         len;
        int         r;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_number", 32'(number_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        rst_ni = 1'b1;
        tick();

        send(4'd5, 1'b1);
        expect_out(9'h020, 4'd1, 2'b00);
        send(4'd0, 1'b0); send(4'd3, 1'b0); send(4'd8, 1'b1);
        expect_out(9'h109, 4'd3, 2'b00);
        send(4'd15, 1'b0); send(4'd2, 1'b0); send(4'd2, 1'b1);
        expect_out(9'h004, 4'd3, 2'b10);
        send(4'd12, 1'b1);
        expect_out(9'h000, 4'd1, 2'b01);

        // Back-to-back one-beat words: out_valid must never drop.
        fork
            begin
                send(4'd1, 1'b1); send(4'd2, 1'b1); send(4'd3, 1'b1); send(4'd4, 1'b1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("b2b_valid", 32'(out_valid_o), 32'd1);
                end
            end
        join
        drain();

        // Backpressure: held word, no acceptance even of a non-last beat.
        out_ready_i = 1'b0;
        send(4'd0, 1'b1);
        expect_out(9'h001, 4'd1, 2'b00);
        in_valid_i = 1'b1; index_i = 4'd3; last_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            check("bp_hold", 32'(number_o), 32'h001);
            tick();
        end
        index_i = 4'd7; last_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        cur.push_back(7);
        close_word();
        expect_out(9'h080, 4'd1, 2'b00);
        drain();

        // Randomized words, lengths past the count saturation point.
        rand_ready = 1'b1;
        for (int w = 0; w < 150; w++) begin
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) tick();
                r = $urandom_range(0, 9);
                if (r < 7)      idx = 4'($urandom_range(0, 8));
                else if (r < 9) idx = 4'hF;
                else            idx = 4'($urandom_range(9, 14));
                send(idx, (b == len - 1));
            end
        end
        drain();

        // Reset mid-word discards the partial accumulation.
        send(4'd1, 1'b0); send(4'd4, 1'b0);
        rst_ni = 1'b0;
        cur.delete();
        sb.delete();
        #1;
        check("midrst_valid", 32'(out_valid_o), 32'd0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        send(4'd6, 1'b1);
        expect_out(9'h040, 4'd1, 2'b00);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/index_accumulator.md
# index_accumulator

Streaming inverse of the leading-one encoder: consumes a valid/ready stream of 4-bit bit indices, decodes each to a 9-bit one-hot, and OR-accumulates beats into a reconstructed 9-bit word that is emitted on a `last` beat. Sits downstream of index-producing logic (priority/leading-one encoders, bit-scan units) and rebuilds the bit vector those indices describe. The null index `4'hF` (all-ones, the encoder's "no bit set" code) contributes no bit. Out-of-range and duplicate indices are flagged.

## Interface
- `WIDTH`, 9: width of the reconstructed word.
- `IDX_W`, 4: index width; `2**IDX_W - 1` is the null code.

- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  input beat accepted when `in_valid_i && in_ready_o`.
- `index_i`  in  IDX_W  bit index; 0..8 valid, 15 null, 9..14 invalid.
- `last_i`  in  1  final beat of the current word.
- `out_valid_o`  out  1  output word valid.
- `out_ready_i`  in  1  downstream accepts word when `out_valid_o && out_ready_i`.
- `number_o`  out  WIDTH  reconstructed word.
- `count_o`  out  IDX_W  accepted beats in the word, saturating at 15.
- `err_o`  out  2  bit0: an invalid index (9..14) was seen; bit1: a duplicate index was seen.

## Operation
- Decode: index k in 0..8 -> `1 << k`. Index 15 -> 0, no error. Index 9..14 -> 0, sets the pending err bit0.
- Duplicate: a decoded bit already set in the accumulator sets the pending err bit1. The word is unchanged (OR is idempotent).
- FSM over the accumulator:
  - IDLE: accumulator, count and pending err are zero.
  - COLLECT: at least one non-last beat has been absorbed.
- Transitions:
  - IDLE -> COLLECT on an accepted non-last beat.
  - COLLECT -> COLLECT on an accepted non-last beat.
  - IDLE or COLLECT -> IDLE on an accepted last beat.
- On an accepted last beat, the final word, count and err are formed as follows and loaded into the output register:
  - word = accumulator | decoded.
  - count = saturating count + 1.
  - err = pending err | this beat's flags.
  - The accumulator is cleared in the same edge.
- A single last beat in IDLE yields a one-beat word (count 1).
- `in_ready_o = !out_valid_o || out_ready_i`. This is combinational from output state only and never depends on `in_valid_i` or `last_i`. It applies to all beats, last or not.
- Output register: `out_valid_o` sets on last-beat load and clears on a handshake with no simultaneous load. While `out_valid_o && !out_ready_i`, `number_o`, `count_o` and `err_o` are held stable.

## Timing
- Reset values:
  - `out_valid_o=0`, `number_o=0`, `count_o=0`, `err_o=0`.
  - FSM IDLE with cleared accumulator.
  - `in_ready_o=1`.
- Latency: last beat accepted at edge N -> `out_valid_o=1` with the word from cycle N+1.
- Throughput: one beat per cycle. Back-to-back one-beat words sustain `out_valid_o=1` every cycle when `out_ready_i=1`.
- Simultaneous output handshake and new last beat: the new word replaces the old one and `out_valid_o` stays 1. No bubble and no loss.
- Backpressure: with `out_valid_o=1` and `out_ready_i=0`, no input beat is accepted, including non-last beats.
- Count saturation: the 16th and later beats keep `count_o` at 15. The word still accumulates.
- Reset mid-word: the partially accumulated word and any held output are discarded. No output follows until a new last beat.
- `in_valid_i` low or beats not accepted: no state change.

## Structure
- Package `leading_one_pkg` holds:
  - `WIDTH`, `IDX_W`, `IDX_NONE = 4'hF`.
  - FSM state enum {IDLE, COLLECT}.
  - The `err_o` bit positions.
- Sub-module `index_to_onehot`: combinational decode of index to a WIDTH-bit one-hot plus an invalid flag. It is reusable wherever the encoder's output must be expanded.

## Test plan
- Reset then a single beat: `index_i=5`, `last_i=1` -> next cycle `number_o=9'h020`, `count_o=1`, `err_o=0`.
- Beats 0, 3, 8 with last on 8 -> `number_o=9'h109`, `count_o=3`, `err_o=0`.
- Beats 15, 2, 2(last) -> `number_o=9'h004`, `count_o=3`, `err_o=2'b10`.
- Beat 12(last) -> `number_o=0`, `err_o=2'b01`.
- Backpressure: `out_ready_i=0` after word `9'h001` -> outputs held and `in_ready_o=0` for 5 cycles. Release with a simultaneous last beat 7 -> the next word `9'h080` follows with no gap.
- Assert `rst_ni=0` after beats 1, 4 (no last), then release; send 6(last) -> `number_o=9'h040`, `count_o=1`.
